// File: rtl/hack_word_uart_tx.sv
// hack_word_uart_tx: sends a 16-bit Hack word as two UART 8N1 frames, low byte first
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   in    : word to send, captured only when load is accepted
//   load  : transmit request, accepted only while busy is low
//   tx    : serial line, idle high
//   busy  : high while a word is in flight
//   done  : one-cycle pulse when the second stop bit completes
module hack_word_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state;
  logic [15:0] hold;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [W-1:0] baud;
  logic        byte_idx;
  logic        tick;
  logic [7:0]  cur;
  assign tick = baud == LAST;
  // byte being framed; read from the holding register so a new `in` cannot disturb it
  assign cur  = byte_idx ? hold[15:8] : hold[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      byte_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) baud <= tick ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (load) begin
          hold     <= in;
          byte_idx <= 1'b0;
          busy     <= 1'b1;
          tx       <= 1'b0;
          baud     <= '0;
          state    <= START;
        end
        START: if (tick) begin
          tx      <= cur[0];
          shift   <= {1'b0, cur[7:1]};
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_cnt == 3'd7) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: if (tick) begin
          if (!byte_idx) begin
            byte_idx <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hack_word_uart_tx.sv
// tb_hack_word_uart_tx: checks the word UART against a bit-list model of the two 8N1 frames
module tb_hack_word_uart_tx;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] in;
  logic load4, load2;
  logic tx4, busy4, done4, tx2, busy2, done2;
  int errors = 0;
  int checks = 0;
  logic cap_tx[$];
  logic cap_busy[$];
  logic cap_done[$];
  always #5 clk = ~clk;
  hack_word_uart_tx #(.CLKS_PER_BIT(4)) u4 (.clk(clk), .rst_n(rst_n), .in(in), .load(load4),
    .tx(tx4), .busy(busy4), .done(done4));
  hack_word_uart_tx #(.CLKS_PER_BIT(2)) u2 (.clk(clk), .rst_n(rst_n), .in(in), .load(load2),
    .tx(tx2), .busy(busy2), .done(done2));
  // expected {tx,busy,done} j cycles after the accepting edge; a second word starts one cycle after done
  function automatic logic [2:0] exp_out(int nw, logic [15:0] w1, logic [15:0] w2, int c, int j);
    int b;
    logic [15:0] w;
    if (nw == 2 && j > 20 * c) begin
      j = j - (20 * c + 1);
      w = w2;
    end else w = w1;
    if (j >= 20 * c) return {1'b1, 1'b0, j == 20 * c};
    b = j / c;
    return {(b % 10 == 0) ? 1'b0 : (b % 10 == 9) ? 1'b1 : w[(b / 10) * 8 + b % 10 - 1], 1'b1, 1'b0};
  endfunction
  // records n cycles of one DUT; kind 1 pulses load with nin at evt, 2 pulses reset at evt, 3 sets in=nin at evt
  task automatic capture(input bit s2, input int n, input int load_len, input int evt,
                         input int kind, input logic [15:0] nin);
    cap_tx.delete(); cap_busy.delete(); cap_done.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cap_tx.push_back(s2 ? tx2 : tx4);
      cap_busy.push_back(s2 ? busy2 : busy4);
      cap_done.push_back(s2 ? done2 : done4);
      if (i + 1 == load_len) begin load4 = 1'b0; load2 = 1'b0; end
      if (kind == 1 && i == evt) begin in = nin; if (s2) load2 = 1'b1; else load4 = 1'b1; end
      if (kind == 1 && i == evt + 1) begin load4 = 1'b0; load2 = 1'b0; end
      if (kind == 2 && i == evt) begin rst_n = 1'b0; #1; rst_n = 1'b1; end
      if (kind == 3 && i == evt) in = nin;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; load4 = 1'b0; load2 = 1'b0; in = '0;
    @(negedge clk);
    checks++;
    if ({tx4, busy4, done4, tx2, busy2, done2} !== 6'b100100) begin
      errors++; $display("FAIL reset_init got=%b%b%b %b%b%b want=100 100", tx4, busy4, done4, tx2, busy2, done2);
    end
    rst_n = 1'b1;
    in = 16'($urandom); load4 = 1'b1;
    capture(0, 12, 1, -1, 0, '0);
    #2; load4 = 1'b1; rst_n = 1'b0;
    #1;
    checks++;
    if ({tx4, busy4, done4} !== 3'b100) begin
      errors++; $display("FAIL reset_async got=%b%b%b want=100", tx4, busy4, done4);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({tx4, busy4, done4} !== 3'b100) begin
        errors++; $display("FAIL reset_held cyc=%0d got=%b%b%b want=100", i, tx4, busy4, done4);
      end
    end
    rst_n = 1'b1; load4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx4, busy4, done4} !== 3'b100) begin
      errors++; $display("FAIL reset_release got=%b%b%b want=100", tx4, busy4, done4);
    end
  endtask
  task automatic test_single(input logic [15:0] w);
    int nb, nd;
    logic [2:0] e;
    nb = 0; nd = 0;
    in = w; load4 = 1'b1;
    capture(0, 90, 1, -1, 0, '0);
    for (int j = 0; j < 90; j++) begin
      e = exp_out(1, w, '0, 4, j);
      nb += int'(cap_busy[j]); nd += int'(cap_done[j]);
      checks++;
      if ({cap_tx[j], cap_busy[j], cap_done[j]} !== e) begin
        errors++; $display("FAIL single_%h cyc=%0d got=%b%b%b want=%b", w, j, cap_tx[j], cap_busy[j], cap_done[j], e);
      end
    end
    checks++;
    if (nb != 80 || nd != 1) begin
      errors++; $display("FAIL single_len_%h busy_cycles=%0d done_cycles=%0d want 80 and 1", w, nb, nd);
    end
  endtask
  task automatic test_ignored_load;
    logic [2:0] e;
    in = 16'h1234; load4 = 1'b1;
    capture(0, 120, 1, 29, 1, 16'hFFFF);
    for (int j = 0; j < 120; j++) begin
      e = exp_out(1, 16'h1234, '0, 4, j);
      checks++;
      if ({cap_tx[j], cap_busy[j], cap_done[j]} !== e) begin
        errors++; $display("FAIL ignored_load cyc=%0d got=%b%b%b want=%b", j, cap_tx[j], cap_busy[j], cap_done[j], e);
      end
    end
  endtask
  task automatic test_back_to_back(input bit s2, input logic [15:0] w1, input logic [15:0] w2);
    int c, n;
    logic [2:0] e;
    c = s2 ? 2 : 4;
    n = 2 * (20 * c + 1) + 4;
    in = w1;
    if (s2) load2 = 1'b1; else load4 = 1'b1;
    capture(s2, n, 20 * c + 2, 0, 3, w2);
    for (int j = 0; j < n; j++) begin
      e = exp_out(2, w1, w2, c, j);
      checks++;
      if ({cap_tx[j], cap_busy[j], cap_done[j]} !== e) begin
        errors++; $display("FAIL b2b_c%0d_%h_%h cyc=%0d got=%b%b%b want=%b", c, w1, w2, j, cap_tx[j], cap_busy[j], cap_done[j], e);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [15:0] w;
    logic [2:0] e;
    w = 16'($urandom);
    in = w; load4 = 1'b1;
    capture(0, 40, 1, 24, 2, '0);
    for (int j = 0; j < 40; j++) begin
      e = (j <= 24) ? exp_out(1, w, '0, 4, j) : 3'b100;
      checks++;
      if ({cap_tx[j], cap_busy[j], cap_done[j]} !== e) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%b%b%b want=%b", j, cap_tx[j], cap_busy[j], cap_done[j], e);
      end
    end
    test_single(16'($urandom));
  endtask
  initial begin
    test_reset();
    test_single(16'hA55A);
    test_ignored_load();
    test_back_to_back(0, 16'h00FF, 16'hFF00);
    test_back_to_back(1, 16'h0000, 16'hFFFF);
    test_back_to_back(0, 16'($urandom), 16'($urandom));
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
